// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that feeds one alu_1bit slice LSB first over WIDTH cycles.
// Define ALU_SERIAL_FLAGS_EN to build the C/Z/O/S flag logic; otherwise the flags read 0.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic             cin_init,
    output logic             alu_op1,
    output logic             alu_op2,
    output logic             alu_cin,
    output logic [2:0]       alu_opsel,
    output logic             alu_mode,
    input  logic             alu_result,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [2:0]       opsel_q, opsel_d;
    logic             mode_q, mode_d;

    logic load;
    logic step;
    logic last;

    // start is honoured in IDLE and DONE alike so ops can run back to back
    assign load = start && (state_q != S_RUN);
    assign step = (state_q == S_RUN);
    assign last = step && (cnt_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        opsel_d  = opsel_q;
        mode_d   = mode_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load) begin
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    opsel_d = opsel;
                    mode_d  = mode;
                    carry_d = cin_init;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {alu_result, res_sh_q[WIDTH-1:1]};
                carry_d  = alu_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    result_d = res_sh_d;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            opsel_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            opsel_q  <= opsel_d;
            mode_q   <= mode_d;
        end
    end

    assign alu_op1   = a_sh_q[0];
    assign alu_op2   = b_sh_q[0];
    assign alu_cin   = carry_q;
    assign alu_opsel = opsel_q;
    assign alu_mode  = mode_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic z_acc_q, z_acc_d;
    logic c_q, c_d;
    logic z_q, z_d;
    logic o_q, o_d;
    logic s_q, s_d;

    always_comb begin
        z_acc_d = z_acc_q;
        c_d     = c_q;
        z_d     = z_q;
        o_d     = o_q;
        s_d     = s_q;
        if (load) begin
            z_acc_d = 1'b1;
        end else if (step) begin
            z_acc_d = z_acc_q & ~alu_result;
            if (last) begin
                c_d = alu_cout;
                s_d = alu_result;
                z_d = z_acc_q & ~alu_result;
                // carry_q still holds the carry into the MSB on this cycle
                o_d = mode_q ? 1'b0 : (carry_q ^ alu_cout);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_acc_q <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            o_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            z_acc_q <= z_acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            o_q     <= o_d;
            s_q     <= s_d;
        end
    end

    assign c_flag = c_q;
    assign z_flag = z_q;
    assign o_flag = o_q;
    assign s_flag = s_q;
`else
    assign c_flag = 1'b0;
    assign z_flag = 1'b0;
    assign o_flag = 1'b0;
    assign s_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (WIDTH=8) with a full-adder slice and an arithmetic reference model.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [2:0]   opsel = '0;
    logic         mode = 1'b0;
    logic         cin_init = 1'b0;
    logic         alu_op1, alu_op2, alu_cin, alu_mode;
    logic [2:0]   alu_opsel;
    logic         alu_result, alu_cout;
    logic         busy, done;
    logic [W-1:0] result;
    logic         c_flag, z_flag, o_flag, s_flag;

    int checks = 0;
    int failures = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .opsel(opsel), .mode(mode), .cin_init(cin_init),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin),
        .alu_opsel(alu_opsel), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .busy(busy), .done(done), .result(result),
        .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag)
    );

    // full-adder stand-in for the slice
    assign alu_result = alu_op1 ^ alu_op2 ^ alu_cin;
    assign alu_cout   = (alu_op1 & alu_op2) | (alu_op1 & alu_cin) | (alu_op2 & alu_cin);

    always #5 clk = ~clk;

    function automatic logic fx(input logic v);
`ifdef ALU_SERIAL_FLAGS_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: operation outcome from plain addition, timing from a countdown
    int           m_left = 0;
    logic         m_done = 1'b0;
    int           pa = 0, pb = 0;
    logic         pci = 1'b0;
    logic [W-1:0] p_res = '0, m_result = '0;
    logic         p_c = 0, p_z = 0, p_o = 0, p_s = 0;
    logic         m_c = 0, m_z = 0, m_o = 0, m_s = 0;
    logic [2:0]   m_opsel = '0;
    logic         m_mode = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_result = '0;
            m_c = 0; m_z = 0; m_o = 0; m_s = 0;
            m_opsel = '0; m_mode = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1; m_result = p_res;
                m_c = p_c; m_z = p_z; m_o = p_o; m_s = p_s;
            end
        end else begin
            m_done = 0;
            if (start) begin
                int sum;
                pa = int'(op_a); pb = int'(op_b); pci = cin_init;
                sum = pa + pb + int'(cin_init);
                p_res = sum[W-1:0];
                p_c = sum[W];
                p_z = (p_res == '0);
                p_s = p_res[W-1];
                p_o = mode ? 1'b0 : ((op_a[W-1] == op_b[W-1]) && (p_res[W-1] != op_a[W-1]));
                m_opsel = opsel; m_mode = mode;
                m_left = W;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("result", 32'(result), 32'(m_result));
        chk("c_flag", 32'(c_flag), 32'(fx(m_c)));
        chk("z_flag", 32'(z_flag), 32'(fx(m_z)));
        chk("o_flag", 32'(o_flag), 32'(fx(m_o)));
        chk("s_flag", 32'(s_flag), 32'(fx(m_s)));
        chk("alu_opsel", 32'(alu_opsel), 32'(m_opsel));
        chk("alu_mode", 32'(alu_mode), 32'(m_mode));
        if (rst) begin
            chk("rst_op1", 32'(alu_op1), 0);
            chk("rst_op2", 32'(alu_op2), 0);
            chk("rst_cin", 32'(alu_cin), 0);
        end else if (m_left > 0) begin
            int k, mask, cin_k;
            k = int'(W) - m_left;
            mask = (1 << k) - 1;
            cin_k = (((pa & mask) + (pb & mask) + int'(pci)) >> k) & 1;
            chk("alu_op1", 32'(alu_op1), (pa >> k) & 1);
            chk("alu_op2", 32'(alu_op2), (pb >> k) & 1);
            chk("alu_cin", 32'(alu_cin), cin_k);
        end
    end

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [2:0] os,
                            input logic md, input logic ci);
        @(negedge clk);
        op_a = a; op_b = b; opsel = os; mode = md; cin_init = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = 8'h5A; op_b = 8'hC3; opsel = 3'b010; mode = ~md; cin_init = ~ci;
    endtask

    // called on the negedge after the start edge; returns negedges until done (bounded)
    task automatic wait_done(input int first, output int lat);
        lat = first;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            failures++;
            $display("FAIL wait_done actual=timeout required=done");
        end
    endtask

    logic [7:0] seq;
    int lat, pulses;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_op1", 32'(alu_op1), 0);
        chk("reset_opsel", 32'(alu_opsel), 0);
        rst = 1'b0;

        // 0x7F + 0x01: signed overflow
        do_start(8'h7F, 8'h01, 3'b000, 1'b0, 1'b0);
        wait_done(1, lat);
        chk("ovf_latency", 32'(lat), 9);
        chk("ovf_result", 32'(result), 32'h80);
        chk("ovf_c", 32'(c_flag), 32'(fx(1'b0)));
        chk("ovf_z", 32'(z_flag), 32'(fx(1'b0)));
        chk("ovf_o", 32'(o_flag), 32'(fx(1'b1)));
        chk("ovf_s", 32'(s_flag), 32'(fx(1'b1)));

        // 0xFF + 0x01 wraps to zero
        do_start(8'hFF, 8'h01, 3'b000, 1'b0, 1'b0);
        wait_done(1, lat);
        chk("wrap_result", 32'(result), 32'h00);
        chk("wrap_c", 32'(c_flag), 32'(fx(1'b1)));
        chk("wrap_z", 32'(z_flag), 32'(fx(1'b1)));
        chk("wrap_o", 32'(o_flag), 32'(fx(1'b0)));
        chk("wrap_s", 32'(s_flag), 32'(fx(1'b0)));

        // carry-in only
        do_start(8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
        wait_done(1, lat);
        chk("cin_result", 32'(result), 32'h01);
        chk("cin_z", 32'(z_flag), 32'(fx(1'b0)));

        // port feed with logic-mode latched controls
        do_start(8'hA5, 8'h00, 3'b101, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            seq[i] = alu_op1;
            chk("feed_opsel", 32'(alu_opsel), 32'h5);
            chk("feed_mode", 32'(alu_mode), 1);
            @(negedge clk);
        end
        chk("feed_op1_seq", 32'(seq), 32'hA5);
        chk("feed_done", 32'(done), 1);
        chk("feed_result", 32'(result), 32'hA5);
        chk("feed_o", 32'(o_flag), 0);

        // start pulsed while busy is ignored
        do_start(8'h02, 8'h03, 3'b000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        op_a = 8'h11; op_b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat);
        chk("busy_start_latency", 32'(lat), 9);
        chk("busy_start_result", 32'(result), 32'h05);

        // back-to-back: start held in the DONE cycle
        op_a = 8'h10; op_b = 8'h20; opsel = 3'b000; mode = 1'b0; cin_init = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_done_once", 32'(done), 0);
        chk("b2b_hold", 32'(result), 32'h05);
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 5) chk("b2b_hold_mid", 32'(result), 32'h05);
        end
        chk("b2b_latency", 32'(lat), 9);
        chk("b2b_result", 32'(result), 32'h30);

        // reset in the middle of an operation
        do_start(8'h0F, 8'h81, 3'b011, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_flags", {28'h0, c_flag, z_flag, o_flag, s_flag}, 0);
        chk("abort_opsel", 32'(alu_opsel), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives one alu_1bit slice over WIDTH clock cycles, LSB first.
- Latches two WIDTH-bit operands plus an opsel/mode pair. Presents one operand bit pair per cycle to the slice and chains the slice's cout back into cin.
- Shifts the slice result into a WIDTH-bit result register and derives C/Z/O/S flags.
- Sits directly upstream (operand/carry feed) and downstream (result/carry capture) of alu_1bit. It is the area-minimal alternative to a WIDTH-wide ripple array.

Parameters:
- WIDTH, 128: operand/result width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH): bit-index counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin; sampled only in IDLE or DONE.
- op_a  input  WIDTH  operand A, captured on accepted start.
- op_b  input  WIDTH  operand B, captured on accepted start.
- opsel  input  3  operation select, captured on accepted start.
- mode  input  1  0 = arithmetic block, 1 = logic block; captured on accepted start.
- cin_init  input  1  carry into bit 0, captured on accepted start.
- alu_op1  output  1  current A bit to slice.
- alu_op2  output  1  current B bit to slice.
- alu_cin  output  1  carry into slice.
- alu_opsel  output  3  latched opsel to slice.
- alu_mode  output  1  latched mode to slice.
- alu_result  input  1  slice result bit (combinational from slice).
- alu_cout  input  1  slice carry out.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  completed result; held until next accepted start.
- c_flag  output  1  carry flag.
- z_flag  output  1  zero flag.
- o_flag  output  1  overflow flag.
- s_flag  output  1  sign flag.

Behaviour:
- Reset (async, active-high): state=IDLE. All registers clear: busy, done, result, flags, the shift registers, the counter and the carry register all go to 0. Consequently alu_op1, alu_op2, alu_cin, alu_opsel and alu_mode all read 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: start=1 loads a_sh=op_a, b_sh=op_b, opsel, mode, carry=cin_init, cnt=0, z_acc=1, then moves to RUN. start=0 stays in IDLE.
- RUN, each cycle:
  - alu_op1=a_sh[0], alu_op2=b_sh[0], alu_cin=carry. alu_opsel and alu_mode are the latched values, constant for the whole operation.
  - On the clock edge:
    - a_sh and b_sh shift right; res_sh shifts right with alu_result inserted at the MSB.
    - carry<=alu_cout.
    - z_acc<=z_acc & ~alu_result.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1, also capture carry_in_msb=carry (the value before the edge). Then load result<=final shifted value, c_flag<=alu_cout, s_flag<=alu_result, z_flag<=z_acc & ~alu_result, and o_flag<=(mode==0) ? (carry ^ alu_cout) : 0. Move to DONE.
- DONE: done=1 for exactly this cycle, with result and flags valid. start=1 here is accepted exactly as in IDLE (back-to-back ops); otherwise return to IDLE.
- Latency: start accepted at edge N, so RUN covers edges N+1..N+WIDTH, done is high in the cycle after edge N+WIDTH, and the throughput is one op per WIDTH+1 cycles.
- start while in RUN is ignored. Operand inputs may change freely after acceptance.
- result and flags hold their last values through IDLE and RUN until the next DONE update.
- Reset during RUN aborts immediately. Outputs return to reset values and there is no done pulse.
- The counter never wraps inside an operation; cnt is don't-care outside RUN.

Optional Feature:
- Macro ALU_SERIAL_FLAGS_EN.
- Defined: c/z/o/s flags are computed as above.
- Undefined: z_acc and the flag registers are not built, and c_flag, z_flag, o_flag and s_flag are tied to 0. result, done, busy and timing are unchanged.

Test Plan:
- Bench setup for all tests: WIDTH=8. The slice is replaced by a full-adder model (alu_result=op1^op2^cin, alu_cout=majority).
- Add with signed overflow: op_a=0x7F, op_b=0x01, cin_init=0, mode=0 -> done exactly 9 cycles after the start edge, result=0x80, c=0, z=0, o=1, s=1.
- Wrap to zero: op_a=0xFF, op_b=0x01 -> result=0x00, c=1, z=1, o=0, s=0. Then op_a=0x00, op_b=0x00, cin_init=1 -> result=0x01, z=0.
- Port feed check: op_a=0xA5, opsel=3'b101, mode=1 -> alu_op1 sequence 1,0,1,0,0,1,0,1 across the RUN cycles. alu_opsel=3'b101 and alu_mode=1 are constant during RUN, and o_flag=0 at done.
- Start while busy: pulse start with op_a=0x11 at RUN cycle 3 of op 0x02+0x03 -> ignored, result=0x05, done pulses once.
- Back-to-back: start held high in the DONE cycle with 0x10+0x20 -> busy reasserts next cycle, the next done comes 9 cycles later with result=0x30, and the previous result stays 0x05 until then.
- Reset mid-run: assert rst at RUN cycle 4 -> busy, done, result and flags go to 0 immediately; no done pulse follows.
